// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles every signal of the load/store unit except clock and reset:
// the CPU request/response handshake and the single-byte data-memory bus.
//
// Signals:
//   req_valid / req_ready   request handshake (CPU -> LSU)
//   req_we, req_word        store select, 16-bit word select
//   req_addr, req_wdata     byte address, store data
//   rsp_valid               one-cycle completion pulse (LSU -> CPU)
//   rsp_rdata, rsp_fault    load data, misalignment fault
//   mem_we, mem_addr,       memory write enable, address, write data (LSU -> mem)
//   mem_wdata
//   mem_rdata               asynchronous memory read data (mem -> LSU)
//
// Modports:
//   master  the environment around the LSU: CPU execute stage plus memory
//   slave   the load/store unit itself
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_word;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output req_valid, req_we, req_word, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_word, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Turns byte / 16-bit word load-store requests from the execute stage into one
// or two single-byte accesses on a 256x8 memory (sync write, async read) and
// returns a one-cycle completion pulse carrying the load data.
// Words are little-endian: low byte at addr, high byte at addr+1 (mod 256).
//
// Ports:
//   clk      clock
//   rst_n    synchronous, active-low reset
//   lsu      load_store_unit_if.slave: request/response handshake + memory bus
//
// Build option:
//   LSU_ALIGN_CHECK_EN  when defined, a word request with an odd address is
//                       answered the next cycle with rsp_fault=1 and performs
//                       no memory access. When undefined rsp_fault is 0 and
//                       odd word addresses are accessed normally.
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; captures it on valid
// LO     | access byte at addr (low byte of a word)
// HI     | access byte at addr+1 (high byte of a word)
// RESP   | rsp_valid pulse with assembled load data
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  lsu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_we;
    logic              r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_rdata_lo;
    logic [7:0]        r_rdata_hi;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_fault;
    logic              w_req_ready;
    logic              w_rsp_valid;
    logic [DATA_W-1:0] w_rsp_rdata;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [7:0]        w_mem_wdata_nxt;

    assign w_accept = (r_state == S_IDLE) && lsu.req_valid;

`ifdef LSU_ALIGN_CHECK_EN
    logic r_fault;

    assign w_misaligned = lsu.req_word && lsu.req_addr[0];
    assign w_fault      = r_fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_fault <= w_misaligned;
        end
    end
`else
    assign w_misaligned = 1'b0;
    assign w_fault      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_req_ready     = 1'b0;
        w_rsp_valid     = 1'b0;
        w_rsp_rdata     = '0;
        w_mem_we        = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        // Memory bus is registered, so present the low byte
                        // for the LO cycle as the request is accepted.
                        w_state_nxt     = S_LO;
                        w_mem_addr_nxt  = lsu.req_addr;
                        w_mem_wdata_nxt = lsu.req_wdata[7:0];
                    end
                end
            end
            S_LO: begin
                w_mem_we = r_we;
                if (r_word) begin
                    w_state_nxt     = S_HI;
                    w_mem_addr_nxt  = r_addr + ADDR_W'(1);
                    w_mem_wdata_nxt = r_wdata[15:8];
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_HI: begin
                w_mem_we    = r_we;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (!r_we && !w_fault) begin
                    w_rsp_rdata = r_word ? {r_rdata_hi, r_rdata_lo}
                                         : {8'h00, r_rdata_lo};
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_word      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata_lo  <= '0;
            r_rdata_hi  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= lsu.req_we;
                r_word  <= lsu.req_word;
                r_addr  <= lsu.req_addr;
                r_wdata <= lsu.req_wdata;
            end
            if (r_state == S_LO && !r_we) begin
                r_rdata_lo <= lsu.mem_rdata;
            end
            if (r_state == S_HI && !r_we) begin
                r_rdata_hi <= lsu.mem_rdata;
            end
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    assign lsu.req_ready = w_req_ready;
    assign lsu.rsp_valid = w_rsp_valid;
    assign lsu.rsp_rdata = w_rsp_rdata;
    assign lsu.rsp_fault = w_rsp_valid & w_fault;
    assign lsu.mem_we    = w_mem_we;
    assign lsu.mem_addr  = r_mem_addr;
    assign lsu.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit. Holds a 256x8 memory behind the
// DUT and a separate byte-array reference of what memory should contain.
// Each request's expected latency, response data, fault flag and list of
// memory writes are computed from the reference before the request is issued.
// Honours LSU_ALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    logic mem_clr;

    int   errors;
    int   checks;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    load_store_unit_if lsu_bus ();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (lsu_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign lsu_bus.mem_rdata = mem[lsu_bus.mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (lsu_bus.mem_we === 1'b1) begin
            mem[lsu_bus.mem_addr] <= lsu_bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic word, input logic [7:0] addr,
                          input logic [15:0] wdata, input string tag);
        logic        fault;
        int          lat_exp;
        logic [15:0] rd_exp;
        logic [15:0] wexp[$];
        logic [15:0] wgot[$];
        logic [7:0]  a_hi;
        int          k;
        bit          got;

        fault = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        fault = word && addr[0];
`endif
        a_hi    = addr + 8'd1;
        lat_exp = fault ? 1 : (word ? 3 : 2);
        rd_exp  = 16'h0000;
        if (!we && !fault) rd_exp = word ? {ref_mem[a_hi], ref_mem[addr]} : {8'h00, ref_mem[addr]};
        if (we && !fault) begin
            wexp.push_back({addr, wdata[7:0]});
            if (word) wexp.push_back({a_hi, wdata[15:8]});
        end

        @(negedge clk);
        chk({tag, " ready_idle"}, 32'(lsu_bus.req_ready), 32'd1);
        lsu_bus.req_valid = 1'b1;
        lsu_bus.req_we    = we;
        lsu_bus.req_word  = word;
        lsu_bus.req_addr  = addr;
        lsu_bus.req_wdata = wdata;
        @(negedge clk);
        // Garbage on the request lines must be ignored once busy.
        lsu_bus.req_valid = 1'b0;
        lsu_bus.req_we    = 1'($urandom);
        lsu_bus.req_word  = 1'($urandom);
        lsu_bus.req_addr  = 8'($urandom);
        lsu_bus.req_wdata = 16'($urandom);

        k   = 1;
        got = 1'b0;
        while (!got && k <= 8) begin
            if (lsu_bus.mem_we === 1'b1) wgot.push_back({lsu_bus.mem_addr, lsu_bus.mem_wdata});
            if (lsu_bus.rsp_valid === 1'b1) begin
                got = 1'b1;
                chk({tag, " latency"}, 32'(k), 32'(lat_exp));
                chk({tag, " rdata"}, 32'(lsu_bus.rsp_rdata), 32'(rd_exp));
                chk({tag, " fault"}, 32'(lsu_bus.rsp_fault), 32'(fault));
            end else begin
                chk({tag, " ready_busy"}, 32'(lsu_bus.req_ready), 32'd0);
                k++;
                @(negedge clk);
            end
        end
        chk({tag, " rsp_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        chk({tag, " rsp_one_cycle"}, 32'(lsu_bus.rsp_valid), 32'd0);
        chk({tag, " ready_again"}, 32'(lsu_bus.req_ready), 32'd1);
        chk({tag, " n_writes"}, 32'(wgot.size()), 32'(wexp.size()));
        for (int i = 0; i < wexp.size() && i < wgot.size(); i++)
            chk($sformatf("%s write%0d", tag, i), 32'(wgot[i]), 32'(wexp[i]));

        if (we && !fault) begin
            ref_mem[addr] = wdata[7:0];
            if (word) ref_mem[a_hi] = wdata[15:8];
        end
    endtask

    initial begin
        bit exp_rdy [8];
        bit exp_rsp [8];
        int pulses;

        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_rsp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        errors  = 0;
        checks  = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        rst_n             = 1'b0;
        mem_clr           = 1'b1;
        lsu_bus.req_valid = 1'b0;
        lsu_bus.req_we    = 1'b0;
        lsu_bus.req_word  = 1'b0;
        lsu_bus.req_addr  = 8'h00;
        lsu_bus.req_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        mem_clr = 1'b0;

        // Reset state
        chk("rst req_ready", 32'(lsu_bus.req_ready), 32'd1);
        chk("rst rsp_valid", 32'(lsu_bus.rsp_valid), 32'd0);
        chk("rst rsp_rdata", 32'(lsu_bus.rsp_rdata), 32'd0);
        chk("rst rsp_fault", 32'(lsu_bus.rsp_fault), 32'd0);
        chk("rst mem_we", 32'(lsu_bus.mem_we), 32'd0);
        chk("rst mem_addr", 32'(lsu_bus.mem_addr), 32'd0);
        chk("rst mem_wdata", 32'(lsu_bus.mem_wdata), 32'd0);

        // Byte store / load
        do_req(1'b1, 1'b0, 8'h10, 16'h00A5, "bst10");
        chk("mem10", 32'(mem[8'h10]), 32'h000000A5);
        do_req(1'b0, 1'b0, 8'h10, 16'h0000, "bld10");

        // Word store / load, little-endian
        do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, "wst20");
        chk("mem20", 32'(mem[8'h20]), 32'h000000EF);
        chk("mem21", 32'(mem[8'h21]), 32'h000000BE);
        do_req(1'b0, 1'b1, 8'h20, 16'h0000, "wld20");

        // Word at 0xFF wraps high byte to 0x00 (misaligned: faults if checking)
        do_req(1'b1, 1'b1, 8'hFF, 16'h1234, "wstFF");
        do_req(1'b0, 1'b1, 8'hFF, 16'h0000, "wldFF");
        chk("memFF", 32'(mem[8'hFF]), 32'(ref_mem[8'hFF]));
        chk("mem00", 32'(mem[8'h00]), 32'(ref_mem[8'h00]));

        // req_valid held high across two byte loads
        @(negedge clk);
        lsu_bus.req_valid = 1'b1;
        lsu_bus.req_we    = 1'b0;
        lsu_bus.req_word  = 1'b0;
        lsu_bus.req_addr  = 8'h10;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("b2b ready c%0d", c), 32'(lsu_bus.req_ready), 32'(exp_rdy[c]));
            chk($sformatf("b2b rsp c%0d", c), 32'(lsu_bus.rsp_valid), 32'(exp_rsp[c]));
            if (lsu_bus.rsp_valid === 1'b1) begin
                pulses++;
                chk($sformatf("b2b rdata%0d", pulses), 32'(lsu_bus.rsp_rdata),
                    32'({8'h00, (pulses == 1) ? ref_mem[8'h10] : ref_mem[8'h20]}));
            end
            if (c == 1) lsu_bus.req_addr = 8'h20;
            if (c == 4) lsu_bus.req_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b pulses", 32'(pulses), 32'd2);

        // Reset during HI of a word store
        lsu_bus.req_valid = 1'b1;
        lsu_bus.req_we    = 1'b1;
        lsu_bus.req_word  = 1'b1;
        lsu_bus.req_addr  = 8'h40;
        lsu_bus.req_wdata = 16'h5678;
        @(negedge clk);
        lsu_bus.req_valid = 1'b0;
        chk("abort lo_we", 32'(lsu_bus.mem_we), 32'd1);
        chk("abort lo_addr", 32'(lsu_bus.mem_addr), 32'h40);
        @(negedge clk);
        chk("abort hi_addr", 32'(lsu_bus.mem_addr), 32'h41);
        chk("abort hi_wdata", 32'(lsu_bus.mem_wdata), 32'h56);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort req_ready", 32'(lsu_bus.req_ready), 32'd1);
        chk("abort rsp_valid", 32'(lsu_bus.rsp_valid), 32'd0);
        chk("abort mem_we", 32'(lsu_bus.mem_we), 32'd0);
        chk("abort mem_addr", 32'(lsu_bus.mem_addr), 32'd0);
        chk("abort mem_wdata", 32'(lsu_bus.mem_wdata), 32'd0);
        chk("abort mem40", 32'(mem[8'h40]), 32'h78);
        ref_mem[8'h40] = 8'h78;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("abort no_rsp c%0d", c), 32'(lsu_bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        // High byte of the aborted store is indeterminate; make it known.
        do_req(1'b1, 1'b0, 8'h41, 16'h00C3, "fix41");

        // Odd-address word load
        do_req(1'b0, 1'b1, 8'h21, 16'h0000, "wld21");

        // Randomised traffic against the reference
        for (int n = 0; n < 40; n++) begin
            do_req(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
                   $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
